// File: rtl/spi_master.sv
// spi_master: host-side SPI master for the 10-bit {cmd, din} frame protocol.
//   clk   - system clock, also the serial bit clock (no SCK output)
//   rst   - synchronous active-high reset
//   start - transaction request, accepted only while busy=0
//   cmd   - 00 wr addr, 01 wr data, 10 rd addr, 11 rd data
//   din   - address or data payload
//   busy  - high from the cycle after accept until the cycle after done
//   done  - one-cycle pulse at end of transaction
//   dout  - read-data result, updated only on a read-data done
//   MOSI  - serial data to slave, MSB first
//   MISO  - serial data from slave, MSB first
//   SS_n  - active-low slave select
module spi_master #(
    parameter int LEAD = 1,
    parameter int TURN = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] cmd,
    input  logic [7:0] din,
    output logic       busy,
    output logic       done,
    output logic [7:0] dout,
    output logic       MOSI,
    input  logic       MISO,
    output logic       SS_n
);
    typedef enum logic [2:0] {S_IDLE, S_LEAD, S_SEND, S_TURN, S_RECV, S_DONE} state_t;

    localparam logic [7:0] LEAD_M1 = 8'(LEAD > 0 ? LEAD - 1 : 0);
    localparam logic [7:0] TURN_M1 = 8'(TURN > 0 ? TURN - 1 : 0);

    state_t     state;
    logic [9:0] frame;
    logic       rd;
    logic [3:0] bit_cnt;
    logic [7:0] wait_cnt;
    logic [7:0] shreg;

    // All outputs are registered: each transition loads the values the
    // destination state presents during its first cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            SS_n     <= 1'b1;
            MOSI     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            dout     <= 8'h00;
            frame    <= 10'd0;
            rd       <= 1'b0;
            bit_cnt  <= 4'd0;
            wait_cnt <= 8'd0;
            shreg    <= 8'h00;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    frame    <= {cmd, din};
                    rd       <= &cmd;
                    busy     <= 1'b1;
                    SS_n     <= 1'b0;
                    MOSI     <= cmd[1];
                    bit_cnt  <= 4'd9;
                    wait_cnt <= LEAD_M1;
                    state    <= (LEAD > 0) ? S_LEAD : S_SEND;
                end
                // MOSI already shows frame[9] and bit_cnt is preset to 9.
                S_LEAD: if (wait_cnt == 8'd0) state <= S_SEND;
                        else wait_cnt <= wait_cnt - 8'd1;
                S_SEND: if (bit_cnt == 4'd0) begin
                    MOSI <= 1'b0;
                    if (rd) begin
                        wait_cnt <= TURN_M1;
                        bit_cnt  <= 4'd7;
                        state    <= (TURN > 0) ? S_TURN : S_RECV;
                    end else begin
                        SS_n  <= 1'b1;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end else begin
                    bit_cnt <= bit_cnt - 4'd1;
                    MOSI    <= frame[bit_cnt - 4'd1];
                end
                S_TURN: if (wait_cnt == 8'd0) state <= S_RECV;
                        else wait_cnt <= wait_cnt - 8'd1;
                S_RECV: begin
                    shreg <= {shreg[6:0], MISO};
                    if (bit_cnt == 4'd0) begin
                        dout  <= {shreg[6:0], MISO};
                        SS_n  <= 1'b1;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        bit_cnt <= bit_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
